adler32_checker: RTL and testbench
==================================

Name: adler32_checker

Overview:
Receive-side companion to the Adler-32 generator. Consumes a byte stream whose last 4 bytes are an Adler-32 checksum (RFC 1950 trailer), recomputes the checksum over the payload bytes, and compares it with the trailer. Reports pass/fail, a runt error, and both checksum values once per frame. Sits on the inbound path behind the byte deframer, one byte per cycle, no backpressure.

Parameters:
ADLER_MOD, 65521, modulus for A and B sums.
CSUM_BIG_ENDIAN, 1, 1 = trailer arrives MSB first (B hi, B lo, A hi, A lo); 0 = LSB first.

Ports:
clock  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_valid  input  1  data/last_data are valid this cycle
data  input  8  stream byte
last_data  input  1  marks final trailer byte of the frame; sampled only when data_valid=1
busy  output  1  frame in progress (at least one byte accepted, last not yet seen)
result_valid  output  1  one-cycle pulse, frame result valid
checksum_ok  output  1  computed == received, qualified by result_valid
runt_error  output  1  frame shorter than 4 bytes, qualified by result_valid
computed_checksum  output  32  {B,A} over the payload
received_checksum  output  32  trailer value, assembled per CSUM_BIG_ENDIAN

Behaviour:
- Reset value of every output register is 0. Internal state: A=1, B=0, hist count n=0.
- Reset is synchronous, active-high, and has priority over everything. Asserting it mid-frame discards the frame with no result_valid.
- hist is a 4-byte delay line, hist0 = newest. n (0..4) counts the valid entries.
- Each accepted byte d (data_valid=1):
  - If n==4, the oldest byte hist3 is folded into the sums: A' = (A + hist3) mod ADLER_MOD, then B' = (B + A') mod ADLER_MOD.
  - Then d shifts into hist0, and n saturates at 4.
- Arithmetic:
  - Intermediate sums are 17 bits wide; modulo is a single conditional subtract (sum >= ADLER_MOD → sum - ADLER_MOD).
  - A and B are stored in 16 bits and always stay < ADLER_MOD.
- data_valid=0: no state change; gaps of any length are allowed mid-frame.
- Accepted byte with last_data=1, and n >= 3 (frame of 4 or more bytes):
  - received = {hist2,hist1,hist0,d} if CSUM_BIG_ENDIAN, else {d,hist0,hist1,hist2}.
  - computed = {B',A'} including the fold of hist3 if n==4; {B,A} if n==3 (empty payload gives 0x00000001).
  - checksum_ok = (computed == received); runt_error = 0.
- Accepted byte with last_data=1 and n < 3: runt_error=1, checksum_ok=0, computed_checksum=0, received_checksum=0.
- Result timing: result_valid pulses exactly 1 cycle after the last_data beat (registered). checksum_ok, runt_error, computed_checksum and received_checksum hold their values until the next result. result_valid is high for that single cycle only.
- In the last_data cycle the frame state re-initialises: A<=1, B<=0, n<=0. A new frame's first byte may therefore arrive in the very next cycle (back-to-back frames, zero bubble).
- busy: 1 from the cycle after the first accepted byte of a frame until the cycle after last_data; 0 otherwise.
- State machine:
  - IDLE (n==0) → FILL (0<n<4) → RUN (n==4).
  - Any state returns to IDLE on an accepted last_data or on reset.
- No length limit: the modulo logic handles arbitrarily long frames.

Test Plan:
- Bytes "Wikipedia" then 11 E6 03 98, last on 0x98 → next cycle result_valid=1, checksum_ok=1, computed=received=0x11E60398, runt_error=0.
- Same frame with trailer 11 E6 03 99 → checksum_ok=0, computed=0x11E60398, received=0x11E60399.
- Empty payload: 00 00 00 01 with last on 0x01 → checksum_ok=1, computed 0x00000001. Then 3-byte frame AA BB CC with last → runt_error=1, checksum_ok=0.
- 300 × 0xFF then trailer B9 0F 2A E4 → checksum_ok=1, computed 0xB90F2AE4 (exercises A wrap: 76501 → 10980).
- Two "Wikipedia" frames back-to-back with no idle cycle, with random data_valid gaps in the second → two result_valid pulses, both checksum_ok=1. busy is low only between the frames.
- Reset asserted for 1 cycle mid-payload, then a valid frame is sent → no result for the aborted frame, a correct pass for the new one. Repeat with CSUM_BIG_ENDIAN=0 and trailer 98 03 E6 11 → checksum_ok=1.

Source files
------------

// File: rtl/adler32_checker_if.sv
// Byte-stream interface for the Adler-32 trailer checker.
// Ports: data_valid/data/last_data (inbound byte stream, no backpressure),
//        busy/result_valid/checksum_ok/runt_error/computed_checksum/received_checksum (frame result).
interface adler32_checker_if;
  logic        data_valid;
  logic [7:0]  data;
  logic        last_data;
  logic        busy;
  logic        result_valid;
  logic        checksum_ok;
  logic        runt_error;
  logic [31:0] computed_checksum;
  logic [31:0] received_checksum;

  // Source of the byte stream / consumer of the frame result.
  modport master (
    output data_valid, data, last_data,
    input  busy, result_valid, checksum_ok, runt_error,
           computed_checksum, received_checksum
  );

  // The checker itself.
  modport slave (
    input  data_valid, data, last_data,
    output busy, result_valid, checksum_ok, runt_error,
           computed_checksum, received_checksum
  );
endinterface

// File: rtl/adler32_checker.sv
// Adler-32 trailer checker: recomputes Adler-32 over a frame's payload and compares it with the 4-byte trailer.
// Latency: result_valid pulses 1 cycle after the last_data beat; one byte per cycle, back-to-back frames allowed.
// Backpressure: none; the stream is always accepted. Ports: clock, rst (sync, active-high), bus (slave modport).
module adler32_checker #(
  parameter int unsigned ADLER_MOD       = 65521,
  parameter bit          CSUM_BIG_ENDIAN = 1'b1
) (
  input  logic               clock,
  input  logic               rst,
  adler32_checker_if.slave   bus
);

  localparam logic [16:0] MOD17 = ADLER_MOD[16:0];

  // IDLE: no bytes held; FILL: 1..3 bytes in the delay line; RUN: delay line full, folding.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [3:0][7:0] hist_q, hist_d;  // hist_q[0] is the newest byte
  logic [2:0]      n_q, n_d;

  logic            busy_q;
  logic            result_valid_q;
  logic            checksum_ok_q;
  logic            runt_error_q;
  logic [31:0]     computed_q;
  logic [31:0]     received_q;

  logic            fold;
  logic            len_ok;
  logic [16:0]     a_sum, a_mod;
  logic [16:0]     b_sum, b_mod;
  logic [31:0]     computed_d;
  logic [31:0]     received_d;

  // The trailer is always the newest 4 bytes, so a byte only enters the sums
  // once it has aged out of the 4-deep delay line.
  assign fold   = (state_q == ST_RUN);
  assign len_ok = fold || (n_q == 3'd3);

  // Both operands are below the modulus, so one conditional subtract is enough.
  always_comb begin
    a_sum = {1'b0, a_q} + {9'b0, hist_q[3]};
    a_mod = (a_sum >= MOD17) ? (a_sum - MOD17) : a_sum;
    b_sum = {1'b0, b_q} + a_mod;
    b_mod = (b_sum >= MOD17) ? (b_sum - MOD17) : b_sum;
  end

  always_comb begin
    a_d     = fold ? a_mod[15:0] : a_q;
    b_d     = fold ? b_mod[15:0] : b_q;
    hist_d  = {hist_q[2:0], bus.data};
    n_d     = fold ? 3'd4 : (n_q + 3'd1);
    state_d = (n_d == 3'd4) ? ST_RUN : ST_FILL;

    computed_d = {b_d, a_d};
    if (CSUM_BIG_ENDIAN) begin
      received_d = {hist_q[2], hist_q[1], hist_q[0], bus.data};
    end else begin
      received_d = {bus.data, hist_q[0], hist_q[1], hist_q[2]};
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      a_q            <= 16'd1;
      b_q            <= 16'd0;
      hist_q         <= '0;
      n_q            <= 3'd0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      checksum_ok_q  <= 1'b0;
      runt_error_q   <= 1'b0;
      computed_q     <= 32'd0;
      received_q     <= 32'd0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.data_valid) begin
        if (bus.last_data) begin
          // Close the frame and re-arm in the same cycle so the next frame's
          // first byte can follow immediately.
          result_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= ST_IDLE;
          a_q            <= 16'd1;
          b_q            <= 16'd0;
          n_q            <= 3'd0;
          hist_q         <= '0;
          if (len_ok) begin
            checksum_ok_q <= (computed_d == received_d);
            runt_error_q  <= 1'b0;
            computed_q    <= computed_d;
            received_q    <= received_d;
          end else begin
            checksum_ok_q <= 1'b0;
            runt_error_q  <= 1'b1;
            computed_q    <= 32'd0;
            received_q    <= 32'd0;
          end
        end else begin
          busy_q  <= 1'b1;
          state_q <= state_d;
          a_q     <= a_d;
          b_q     <= b_d;
          hist_q  <= hist_d;
          n_q     <= n_d;
        end
      end
    end
  end

  assign bus.busy              = busy_q;
  assign bus.result_valid      = result_valid_q;
  assign bus.checksum_ok       = checksum_ok_q;
  assign bus.runt_error        = runt_error_q;
  assign bus.computed_checksum = computed_q;
  assign bus.received_checksum = received_q;

endmodule

// File: tb/tb_adler32_checker.sv
// Self-checking bench for adler32_checker: directed frames on a big-endian and a little-endian instance.
// Expected results are queued at the last byte; per-instance monitors pop and compare on result_valid.
// Ports: none (top-level bench).
module tb_adler32_checker;

  logic       clock = 1'b0;
  logic       rst;
  logic       dv;
  logic       ld;
  logic       sel_le;
  logic [7:0] dat;

  always #5 clock = ~clock;

  adler32_checker_if bus_be ();
  adler32_checker_if bus_le ();

  assign bus_be.data_valid = dv & ~sel_le;
  assign bus_be.data       = dat;
  assign bus_be.last_data  = ld;
  assign bus_le.data_valid = dv & sel_le;
  assign bus_le.data       = dat;
  assign bus_le.last_data  = ld;

  adler32_checker #(.ADLER_MOD(65521), .CSUM_BIG_ENDIAN(1'b1)) dut_be (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_be)
  );

  adler32_checker #(.ADLER_MOD(65521), .CSUM_BIG_ENDIAN(1'b0)) dut_le (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_le)
  );

  typedef struct {
    logic        ok;
    logic        runt;
    logic [31:0] comp;
    logic [31:0] recv;
    int          due;
  } exp_t;

  exp_t q_be[$];
  exp_t q_le[$];
  logic [7:0] fq[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitors: one per instance.
  always @(negedge clock) begin
    if (bus_be.result_valid === 1'b1) begin
      if (q_be.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL be_unexpected_result: got result_valid=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q_be.pop_front();
        chk("be_cycle", 32'(cyc), 32'(e.due));
        chk("be_checksum_ok", {31'd0, bus_be.checksum_ok}, {31'd0, e.ok});
        chk("be_runt_error", {31'd0, bus_be.runt_error}, {31'd0, e.runt});
        chk("be_computed", bus_be.computed_checksum, e.comp);
        chk("be_received", bus_be.received_checksum, e.recv);
      end
    end
  end

  always @(negedge clock) begin
    if (bus_le.result_valid === 1'b1) begin
      if (q_le.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL le_unexpected_result: got result_valid=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q_le.pop_front();
        chk("le_cycle", 32'(cyc), 32'(e.due));
        chk("le_checksum_ok", {31'd0, bus_le.checksum_ok}, {31'd0, e.ok});
        chk("le_runt_error", {31'd0, bus_le.runt_error}, {31'd0, e.runt});
        chk("le_computed", bus_le.computed_checksum, e.comp);
        chk("le_received", bus_le.received_checksum, e.recv);
      end
    end
  end

  // Every task below starts and ends 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic l);
    dv  = 1'b1;
    dat = d;
    ld  = l;
    @(posedge clock);
    #1;
    dv  = 1'b0;
    ld  = 1'b0;
  endtask

  task automatic push_wiki();
    fq.push_back(8'h57); fq.push_back(8'h69); fq.push_back(8'h6B);
    fq.push_back(8'h69); fq.push_back(8'h70); fq.push_back(8'h65);
    fq.push_back(8'h64); fq.push_back(8'h69); fq.push_back(8'h61);
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    fq.push_back(b0); fq.push_back(b1); fq.push_back(b2); fq.push_back(b3);
  endtask

  // Sends fq as one frame (last_data on the final byte), queues the expected result.
  task automatic send_frame(input bit le, input int max_gap, input logic ok, input logic runt,
                            input logic [31:0] comp, input logic [31:0] recv);
    int   len;
    exp_t e;
    len    = fq.size();
    sel_le = le;
    for (int i = 0; i < len; i++) begin
      if (max_gap > 0 && i > 0) idle($urandom_range(0, max_gap));
      if (i == len - 1) begin
        e.ok   = ok;
        e.runt = runt;
        e.comp = comp;
        e.recv = recv;
        e.due  = cyc + 1;
        if (le) q_le.push_back(e);
        else    q_be.push_back(e);
        drive(fq[i], 1'b1);
        chk(le ? "le_busy_after_last" : "be_busy_after_last",
            {31'd0, le ? bus_le.busy : bus_be.busy}, 32'd0);
      end else begin
        drive(fq[i], 1'b0);
        if (i == 0) begin
          chk(le ? "le_busy_after_first" : "be_busy_after_first",
              {31'd0, le ? bus_le.busy : bus_be.busy}, 32'd1);
        end
      end
    end
    fq.delete();
  endtask

  task automatic abort_mid_frame(input bit le);
    sel_le = le;
    drive(8'h57, 1'b0);
    drive(8'h69, 1'b0);
    drive(8'h6B, 1'b0);
    drive(8'h69, 1'b0);
    drive(8'h70, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk(le ? "le_busy_after_reset" : "be_busy_after_reset",
        {31'd0, le ? bus_le.busy : bus_be.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    dv     = 1'b0;
    ld     = 1'b0;
    dat    = 8'h00;
    sel_le = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state.
    @(negedge clock);
    chk("rst_result_valid", {31'd0, bus_be.result_valid}, 32'd0);
    chk("rst_checksum_ok", {31'd0, bus_be.checksum_ok}, 32'd0);
    chk("rst_runt_error", {31'd0, bus_be.runt_error}, 32'd0);
    chk("rst_computed", bus_be.computed_checksum, 32'd0);
    chk("rst_received", bus_be.received_checksum, 32'd0);
    chk("rst_busy", {31'd0, bus_be.busy}, 32'd0);
    chk("rst_le_busy", {31'd0, bus_le.busy}, 32'd0);
    chk("rst_le_computed", bus_le.computed_checksum, 32'd0);
    @(posedge clock);
    #1;

    // "Wikipedia" with the correct trailer.
    push_wiki();
    push4(8'h11, 8'hE6, 8'h03, 8'h98);
    send_frame(1'b0, 0, 1'b1, 1'b0, 32'h11E60398, 32'h11E60398);
    idle(4);
    chk("hold_computed", bus_be.computed_checksum, 32'h11E60398);
    chk("hold_checksum_ok", {31'd0, bus_be.checksum_ok}, 32'd1);
    chk("pulse_dropped", {31'd0, bus_be.result_valid}, 32'd0);

    // Corrupted trailer.
    push_wiki();
    push4(8'h11, 8'hE6, 8'h03, 8'h99);
    send_frame(1'b0, 0, 1'b0, 1'b0, 32'h11E60398, 32'h11E60399);
    idle(2);

    // Empty payload, then a 3-byte runt.
    push4(8'h00, 8'h00, 8'h00, 8'h01);
    send_frame(1'b0, 0, 1'b1, 1'b0, 32'h00000001, 32'h00000001);
    fq.push_back(8'hAA); fq.push_back(8'hBB); fq.push_back(8'hCC);
    send_frame(1'b0, 0, 1'b0, 1'b1, 32'h0, 32'h0);
    idle(2);

    // 300 x 0xFF: A wraps 76501 -> 10980.
    for (int i = 0; i < 300; i++) fq.push_back(8'hFF);
    push4(8'hB9, 8'h0F, 8'h2A, 8'hE4);
    send_frame(1'b0, 0, 1'b1, 1'b0, 32'hB90F2AE4, 32'hB90F2AE4);

    // Back-to-back frames, second one with random gaps.
    push_wiki();
    push4(8'h11, 8'hE6, 8'h03, 8'h98);
    send_frame(1'b0, 0, 1'b1, 1'b0, 32'h11E60398, 32'h11E60398);
    push_wiki();
    push4(8'h11, 8'hE6, 8'h03, 8'h98);
    send_frame(1'b0, 2, 1'b1, 1'b0, 32'h11E60398, 32'h11E60398);
    idle(2);

    // Reset mid-payload, then a clean frame.
    abort_mid_frame(1'b0);
    push_wiki();
    push4(8'h11, 8'hE6, 8'h03, 8'h98);
    send_frame(1'b0, 0, 1'b1, 1'b0, 32'h11E60398, 32'h11E60398);
    idle(2);

    // Little-endian instance: same sequence, trailer LSB first.
    abort_mid_frame(1'b1);
    push_wiki();
    push4(8'h98, 8'h03, 8'hE6, 8'h11);
    send_frame(1'b1, 0, 1'b1, 1'b0, 32'h11E60398, 32'h11E60398);
    idle(5);

    chk("be_results_outstanding", 32'(q_be.size()), 32'd0);
    chk("le_results_outstanding", 32'(q_le.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
